// File: rtl/bmp_loader_pkg.sv
// Package: bmp_loader_pkg
// Shared definitions for the BMP stream loader: FSM state encoding and the
// byte offsets of the header fields the loader captures.
package bmp_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PIXELS,
    DRAIN,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned OFS_MAGIC0   = 0;
  localparam int unsigned OFS_DATA     = 10;
  localparam int unsigned OFS_WIDTH    = 18;
  localparam int unsigned OFS_HEIGHT   = 22;
  localparam int unsigned OFS_HSIGN    = 25;
  localparam int unsigned OFS_BPP      = 28;
  localparam int unsigned HDR_LAST     = 29;
  localparam int unsigned MIN_DATA_OFS = 30;

  localparam logic [15:0] BMP_MAGIC = 16'h4D42;

endpackage

// File: rtl/bmp_stream_loader_fifo.sv
// Module: bmp_byte_fifo
// Synchronous FIFO holding {sram_addr, byte} pairs between the byte stream
// and the SRAM write port.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : empties the FIFO (wins over push/pop)
//   push, din  : write request and data; accepted when not full, or when full
//                and a pop happens in the same cycle
//   pop        : remove head (ignored when empty)
//   dout       : current head entry
//   full/empty : occupancy flags
module bmp_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  // DEPTH is a power of two, so the count MSB alone marks "full".
  assign full  = count_q[PTR_W];
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty && !flush;
    do_push  = push && (!full || do_pop) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bmp_stream_loader.sv
// Module: bmp_stream_loader
// Parses a BMP file arriving on the data_io byte stream, validates the
// header, and writes the pixel bytes to SRAM through a req/ack port.
//   clk_sys, reset            : clock, asynchronous active-high reset
//   ioctl_download/wr/addr/dout : download window, byte strobe, offset, byte
//   wr_req/wr_addr/wr_data/wr_ack : SRAM byte write handshake
//   img_width/img_height      : parsed dimensions (height as absolute value)
//   bmp_loaded                : all pixel bytes committed
//   hdr_error                 : header rejected or download truncated
//   overflow                  : sticky, a pixel byte hit a full FIFO
// Build option: define BMP_LOADER_ROWFLIP_EN to place rows at a fixed
// 2**STRIDE_LOG2 stride with bottom-up files flipped to top-down order.
module bmp_stream_loader
  import bmp_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned STRIDE_LOG2 = 11,
  parameter int unsigned REQ_BPP     = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack,
  output logic [15:0]       img_width,
  output logic [15:0]       img_height,
  output logic              bmp_loaded,
  output logic              hdr_error,
  output logic              overflow
);

  state_t        state_q, state_d;
  logic          wr_prev_q, dl_prev_q;
  logic [15:0]   magic_q, magic_d;
  logic [23:0]   offset_q, offset_d;
  logic [15:0]   width_q, width_d;
  logic [15:0]   hraw_q, hraw_d;
  logic          topdown_q, topdown_d;
  logic [7:0]    bpp_lo_q, bpp_lo_d;
  logic          loaded_q, loaded_d;
  logic          hdr_err_q, hdr_err_d;
  logic          ovf_q, ovf_d;
`ifdef BMP_LOADER_ROWFLIP_EN
  logic [15:0]            row_q, row_d;
  logic [STRIDE_LOG2-1:0] col_q, col_d;
  logic [15:0]            row_sel;
`endif

  logic              byte_ev, dl_rise, dl_fall;
  logic              is_pixel, hdr_ok;
  logic [24:0]       pix_ofs;
  logic [15:0]       height_abs;
  logic [15:0]       bpp_full;
  logic              fifo_flush, push_req, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W+7:0] fifo_dout;

  assign byte_ev    = ioctl_wr && !wr_prev_q;
  assign dl_rise    = ioctl_download && !dl_prev_q;
  assign dl_fall    = !ioctl_download && dl_prev_q;
  assign height_abs = topdown_q ? (~hraw_q + 16'd1) : hraw_q;
  assign is_pixel   = (ioctl_addr >= {1'b0, offset_q});
  assign pix_ofs    = ioctl_addr - {1'b0, offset_q};
  // Byte 29 is being captured this cycle, so bpp is checked from the live byte.
  assign bpp_full   = {ioctl_dout, bpp_lo_q};
  assign hdr_ok     = (magic_q == BMP_MAGIC) && (bpp_full == 16'(REQ_BPP)) &&
                      (width_q != '0) && (hraw_q != '0) &&
                      ((32'(width_q) << 2) <= (32'd1 << STRIDE_LOG2)) &&
                      (offset_q >= 24'(MIN_DATA_OFS));

  always_comb begin
    state_d    = state_q;
    magic_d    = magic_q;
    offset_d   = offset_q;
    width_d    = width_q;
    hraw_d     = hraw_q;
    topdown_d  = topdown_q;
    bpp_lo_d   = bpp_lo_q;
    loaded_d   = loaded_q;
    hdr_err_d  = hdr_err_q;
    ovf_d      = ovf_q;
    fifo_flush = 1'b0;
    push_req   = 1'b0;
    push_addr  = '0;
`ifdef BMP_LOADER_ROWFLIP_EN
    row_d      = row_q;
    col_d      = col_q;
    row_sel    = topdown_q ? row_q : (height_abs - 16'd1 - row_q);
`endif

    if (dl_rise) begin
      state_d    = HEADER;
      magic_d    = '0;
      offset_d   = '0;
      width_d    = '0;
      hraw_d     = '0;
      topdown_d  = 1'b0;
      bpp_lo_d   = '0;
      loaded_d   = 1'b0;
      hdr_err_d  = 1'b0;
      ovf_d      = 1'b0;
      fifo_flush = 1'b1;
`ifdef BMP_LOADER_ROWFLIP_EN
      row_d      = '0;
      col_d      = '0;
`endif
    end else begin
      unique case (state_q)
        HEADER: begin
          if (dl_fall) begin
            state_d   = ERROR;
            hdr_err_d = 1'b1;
          end else if (byte_ev && (ioctl_addr[24:5] == '0)) begin
            case (ioctl_addr[4:0])
              5'(OFS_MAGIC0):     magic_d[7:0]    = ioctl_dout;
              5'(OFS_MAGIC0 + 1): magic_d[15:8]   = ioctl_dout;
              5'(OFS_DATA):       offset_d[7:0]   = ioctl_dout;
              5'(OFS_DATA + 1):   offset_d[15:8]  = ioctl_dout;
              5'(OFS_DATA + 2):   offset_d[23:16] = ioctl_dout;
              5'(OFS_WIDTH):      width_d[7:0]    = ioctl_dout;
              5'(OFS_WIDTH + 1):  width_d[15:8]   = ioctl_dout;
              5'(OFS_HEIGHT):     hraw_d[7:0]     = ioctl_dout;
              5'(OFS_HEIGHT + 1): hraw_d[15:8]    = ioctl_dout;
              5'(OFS_HSIGN):      topdown_d       = ioctl_dout[7];
              5'(OFS_BPP):        bpp_lo_d        = ioctl_dout;
              5'(HDR_LAST): begin
                if (hdr_ok) begin
                  state_d = PIXELS;
                end else begin
                  state_d   = ERROR;
                  hdr_err_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        PIXELS: begin
          if (dl_fall) state_d = DRAIN;
          if (byte_ev && is_pixel) begin
`ifdef BMP_LOADER_ROWFLIP_EN
            // Counters stop once past the last row so trailing bytes stay dropped.
            if (row_q < height_abs) begin
              push_req  = 1'b1;
              push_addr = ADDR_W'((32'(row_sel) << STRIDE_LOG2) | 32'(col_q));
              if (32'(col_q) == (32'(width_q) << 2) - 32'd1) begin
                col_d = '0;
                row_d = row_q + 16'd1;
              end else begin
                col_d = col_q + STRIDE_LOG2'(1);
              end
            end
`else
            push_req  = 1'b1;
            push_addr = ADDR_W'(pix_ofs);
`endif
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_d  = DONE;
            loaded_d = 1'b1;
          end
        end
        IDLE, DONE, ERROR: ;
        default: state_d = IDLE;
      endcase
    end

    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_prev_q <= 1'b0;
      dl_prev_q <= 1'b0;
      magic_q   <= '0;
      offset_q  <= '0;
      width_q   <= '0;
      hraw_q    <= '0;
      topdown_q <= 1'b0;
      bpp_lo_q  <= '0;
      loaded_q  <= 1'b0;
      hdr_err_q <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef BMP_LOADER_ROWFLIP_EN
      row_q     <= '0;
      col_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_prev_q <= ioctl_wr;
      dl_prev_q <= ioctl_download;
      magic_q   <= magic_d;
      offset_q  <= offset_d;
      width_q   <= width_d;
      hraw_q    <= hraw_d;
      topdown_q <= topdown_d;
      bpp_lo_q  <= bpp_lo_d;
      loaded_q  <= loaded_d;
      hdr_err_q <= hdr_err_d;
      ovf_q     <= ovf_d;
`ifdef BMP_LOADER_ROWFLIP_EN
      row_q     <= row_d;
      col_q     <= col_d;
`endif
    end
  end

  assign fifo_pop = wr_ack && wr_req;

  bmp_byte_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ADDR_W + 8)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .flush (fifo_flush),
    .push  (push_req),
    .din   ({push_addr, ioctl_dout}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head is gated so the port reads all-zero whenever nothing is pending.
  assign wr_req     = !fifo_empty;
  assign wr_addr    = wr_req ? fifo_dout[ADDR_W+7:8] : '0;
  assign wr_data    = wr_req ? fifo_dout[7:0] : '0;
  assign img_width  = width_q;
  assign img_height = height_abs;
  assign bmp_loaded = loaded_q;
  assign hdr_error  = hdr_err_q;
  assign overflow   = ovf_q;

endmodule
